// File: rtl/multi_pdet_combiner.sv
// multi_pdet_combiner: per-channel signed edge-offset phase detectors feeding a
// once-per-generated-period summing stage for the ADPLL loop filter.
module multi_pdet_combiner #(
    parameter int  N_CH    = 4,
    parameter int  WIDTH   = 8,
    parameter int  TIMEOUT = 200,
    localparam int SW      = WIDTH + $clog2(N_CH) + 1
) (
    input  logic                  fpga_clk_i,
    input  logic                  reset_ni,
    input  logic                  enable_i,
    input  logic [N_CH-1:0]       ch_en_i,
    input  logic [N_CH-1:0]       invert_i,
    input  logic [N_CH-1:0]       ref_i,
    input  logic                  gen_i,
    output logic [N_CH*WIDTH-1:0] pd_err_o,
    output logic [N_CH-1:0]       timeout_o,
    output logic signed [SW-1:0]  err_sum_o,
    output logic [3:0]            active_o,
    output logic                  err_valid_o
);
    typedef enum logic [1:0] {IDLE, REF_LEAD, GEN_LEAD} state_t;

    localparam logic [WIDTH-1:0] MAX_ERR = WIDTH'((1 << (WIDTH-1)) - 1);
    localparam logic [WIDTH-1:0] TO_CNT  = WIDTH'(TIMEOUT);

    // gen sits in the MSB so every clock shares one synchroniser bank
    logic [N_CH:0]   sync1, sync2, sync_d;
    logic [N_CH:0]   rise;
    logic [N_CH-1:0] rise_ref;
    logic            rise_gen;
    logic [N_CH-1:0] fresh;

    // two-flop synchronisers plus edge register, identical latency for all inputs
    always_ff @(posedge fpga_clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sync1  <= '0;
            sync2  <= '0;
            sync_d <= '0;
        end else begin
            sync1  <= {gen_i, ref_i};
            sync2  <= sync1;
            sync_d <= sync2;
        end
    end

    assign rise     = sync2 & ~sync_d;
    assign rise_ref = rise[N_CH-1:0];
    assign rise_gen = rise[N_CH];

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        state_t           state, state_nx;
        logic [WIDTH-1:0] cnt, cnt_nx;   // cycles elapsed since the opening edge
        logic [WIDTH-1:0] sat_cnt, mag, err_nx, err_q;
        logic             run, lat, lat_to, neg;
        logic             to_q, fresh_q;

        assign run     = enable_i & ch_en_i[k];
        assign sat_cnt = (cnt > MAX_ERR) ? MAX_ERR : cnt;
        // reciprocal links flip sign; range is symmetric so negation never wraps
        assign err_nx  = (neg ^ invert_i[k]) ? (~mag + 1'b1) : mag;

        // channel state register
        always_ff @(posedge fpga_clk_i or negedge reset_ni) begin
            if (!reset_ni) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                state <= state_nx;
                cnt   <= cnt_nx;
            end
        end

        // open on first edge, close on the opposite edge, or force-close on timeout
        always_comb begin
            state_nx = state;
            cnt_nx   = cnt;
            lat      = 1'b0;
            lat_to   = 1'b0;
            neg      = 1'b0;
            mag      = '0;
            if (!run) begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (rise_ref[k] && rise_gen) begin
                            lat = 1'b1;
                        end else if (rise_ref[k]) begin
                            state_nx = REF_LEAD;
                            cnt_nx   = WIDTH'(1);
                        end else if (rise_gen) begin
                            state_nx = GEN_LEAD;
                            cnt_nx   = WIDTH'(1);
                        end
                    end
                    REF_LEAD: begin
                        if (rise_gen) begin
                            lat = 1'b1;
                            mag = sat_cnt;
                            // a coincident ref edge opens the next measurement
                            state_nx = rise_ref[k] ? REF_LEAD : IDLE;
                            cnt_nx   = rise_ref[k] ? WIDTH'(1) : '0;
                        end else if (rise_ref[k]) begin
                            cnt_nx = WIDTH'(1);
                        end else if (cnt == TO_CNT) begin
                            lat      = 1'b1;
                            lat_to   = 1'b1;
                            mag      = MAX_ERR;
                            state_nx = IDLE;
                            cnt_nx   = '0;
                        end else begin
                            cnt_nx = cnt + 1'b1;
                        end
                    end
                    GEN_LEAD: begin
                        neg = 1'b1;
                        if (rise_ref[k]) begin
                            lat = 1'b1;
                            mag = sat_cnt;
                            state_nx = rise_gen ? GEN_LEAD : IDLE;
                            cnt_nx   = rise_gen ? WIDTH'(1) : '0;
                        end else if (rise_gen) begin
                            cnt_nx = WIDTH'(1);
                        end else if (cnt == TO_CNT) begin
                            lat      = 1'b1;
                            lat_to   = 1'b1;
                            mag      = MAX_ERR;
                            state_nx = IDLE;
                            cnt_nx   = '0;
                        end else begin
                            cnt_nx = cnt + 1'b1;
                        end
                    end
                    default: state_nx = IDLE;
                endcase
            end
        end

        // latched error, sticky timeout flag and fresh flag for the combiner
        always_ff @(posedge fpga_clk_i or negedge reset_ni) begin
            if (!reset_ni) begin
                err_q   <= '0;
                to_q    <= 1'b0;
                fresh_q <= 1'b0;
            end else begin
                if (lat) begin
                    err_q <= err_nx;
                    to_q  <= lat_to;
                end
                // a latch on the snapshot edge itself belongs to the next window
                if (!run)          fresh_q <= 1'b0;
                else if (lat)      fresh_q <= 1'b1;
                else if (rise_gen) fresh_q <= 1'b0;
            end
        end

        assign pd_err_o[k*WIDTH +: WIDTH] = err_q;
        assign timeout_o[k]               = to_q;
        assign fresh[k]                   = fresh_q;
    end

    logic [1:0]            vld_pipe;
    logic [N_CH-1:0]       snap_m;
    logic [N_CH*WIDTH-1:0] snap_e;
    logic signed [SW-1:0]  sum_c;
    logic [3:0]            act_c;

    // sign-extended sum and count of the snapshotted channels
    always_comb begin
        sum_c = '0;
        act_c = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (snap_m[k]) begin
                sum_c = sum_c + {{(SW-WIDTH){snap_e[k*WIDTH+WIDTH-1]}}, snap_e[k*WIDTH +: WIDTH]};
                act_c = act_c + 4'd1;
            end
        end
    end

    // snapshot on each generated edge, publish two cycles later
    always_ff @(posedge fpga_clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            vld_pipe  <= '0;
            snap_m    <= '0;
            snap_e    <= '0;
            err_sum_o <= '0;
            active_o  <= '0;
        end else begin
            vld_pipe[0] <= rise_gen & enable_i;
            vld_pipe[1] <= vld_pipe[0] & enable_i;
            if (rise_gen && enable_i) begin
                snap_m <= fresh & ch_en_i;
                snap_e <= pd_err_o;
            end
            if (vld_pipe[0] && enable_i) begin
                err_sum_o <= sum_c;
                active_o  <= act_c;
            end
        end
    end

    assign err_valid_o = vld_pipe[1];

endmodule

// File: tb/tb_multi_pdet_combiner.sv
// tb_multi_pdet_combiner: directed spec cases plus random clock bursts, checked
// against a timestamp-based reference model through a result queue.
module tb_multi_pdet_combiner;
    localparam int N    = 4;
    localparam int W    = 8;
    localparam int TO   = 200;
    localparam int MAXV = 127;
    localparam int SW   = W + $clog2(N) + 1;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               ena = 1'b0;
    logic [N-1:0]       chen = '0;
    logic [N-1:0]       inv = '0;
    logic [N-1:0]       refv = '0;
    logic               genv = 1'b0;
    logic [N*W-1:0]     pd_err;
    logic [N-1:0]       tmo;
    logic signed [SW-1:0] sum;
    logic [3:0]         act;
    logic               vld;

    int n_vec = 0;
    int n_err = 0;

    // reference model: open edge kind and timestamp per channel
    int  m_open[N];   // 0 none, 1 ref opened, 2 gen opened
    int  m_t[N];
    int  m_err[N];
    bit  m_to[N];
    bit  m_fresh[N];
    logic [N-1:0] m_prev_r = '0;
    logic         m_prev_g = 1'b0;
    int  m_cyc = 0;
    int  q_sum[$];
    int  q_act[$];

    int  cap_sum, cap_act, cap_cnt;

    multi_pdet_combiner #(.N_CH(N), .WIDTH(W), .TIMEOUT(TO)) dut (
        .fpga_clk_i (clk),
        .reset_ni   (rst_n),
        .enable_i   (ena),
        .ch_en_i    (chen),
        .invert_i   (inv),
        .ref_i      (refv),
        .gen_i      (genv),
        .pd_err_o   (pd_err),
        .timeout_o  (tmo),
        .err_sum_o  (sum),
        .active_o   (act),
        .err_valid_o(vld)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint a, input longint e);
        n_vec++;
        if (a != e) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, a, e);
        end
    endtask

    function automatic int err_of(input int k);
        logic signed [W-1:0] v;
        v = pd_err[k*W +: W];
        return int'(v);
    endfunction

    function automatic void m_latch(input int k, input int v, input bit to);
        m_err[k]   = inv[k] ? -v : v;
        m_to[k]    = to;
        m_fresh[k] = 1'b1;
    endfunction

    function automatic void m_reset();
        for (int k = 0; k < N; k++) begin
            m_open[k] = 0; m_t[k] = 0; m_err[k] = 0; m_to[k] = 0; m_fresh[k] = 0;
        end
        m_prev_r = '0;
        m_prev_g = 1'b0;
        q_sum.delete();
        q_act.delete();
    endfunction

    // one input cycle: D is the distance between raw rising edges
    function automatic void model_step(input logic [N-1:0] r, input logic g);
        logic [N-1:0] rr;
        logic         rg;
        int           d, s, a;
        rr = r & ~m_prev_r;
        rg = g & ~m_prev_g;
        m_prev_r = r;
        m_prev_g = g;
        if (ena && rg) begin
            s = 0; a = 0;
            for (int k = 0; k < N; k++)
                if (m_fresh[k]) begin s += m_err[k]; a++; end
            q_sum.push_back(s);
            q_act.push_back(a);
        end
        if (rg) for (int k = 0; k < N; k++) m_fresh[k] = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!(ena && chen[k])) begin
                m_open[k] = 0;
                m_fresh[k] = 1'b0;
            end else begin
                d = m_cyc - m_t[k];
                if (m_open[k] == 0) begin
                    if (rr[k] && rg) m_latch(k, 0, 0);
                    else if (rr[k]) begin m_open[k] = 1; m_t[k] = m_cyc; end
                    else if (rg)    begin m_open[k] = 2; m_t[k] = m_cyc; end
                end else if (m_open[k] == 1) begin
                    if (rg) begin
                        m_latch(k, (d > MAXV) ? MAXV : d, 0);
                        if (rr[k]) m_t[k] = m_cyc; else m_open[k] = 0;
                    end else if (rr[k]) m_t[k] = m_cyc;
                    else if (d == TO) begin m_latch(k, MAXV, 1); m_open[k] = 0; end
                end else begin
                    if (rr[k]) begin
                        m_latch(k, (d > MAXV) ? -MAXV : -d, 0);
                        if (rg) m_t[k] = m_cyc; else m_open[k] = 0;
                    end else if (rg) m_t[k] = m_cyc;
                    else if (d == TO) begin m_latch(k, -MAXV, 1); m_open[k] = 0; end
                end
            end
        end
        m_cyc++;
    endfunction

    task automatic cyc_drive(input logic [N-1:0] r, input logic g);
        @(negedge clk);
        if (vld) begin cap_sum = sum; cap_act = act; cap_cnt++; end
        refv = r;
        genv = g;
        model_step(r, g);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc_drive('0, 1'b0);
    endtask

    // single-cycle ref pulses on rm at rt, gen pulse at gt
    task automatic pair(input logic [N-1:0] rm, input int rt, input int gt);
        int len;
        len = ((rt > gt) ? rt : gt) + 1;
        for (int t = 0; t < len; t++) cyc_drive({N{t == rt}} & rm, t == gt);
    endtask

    task automatic cap_clear();
        cap_cnt = 0; cap_sum = 0; cap_act = 0;
    endtask

    task automatic check_state(input string tag);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("%s_pd_err%0d", tag, k), err_of(k), m_err[k]);
            chk($sformatf("%s_timeout%0d", tag, k), tmo[k], m_to[k]);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_pd_err"}, pd_err, 0);
        chk({tag, "_timeout"}, tmo, 0);
        chk({tag, "_sum"}, sum, 0);
        chk({tag, "_active"}, act, 0);
        chk({tag, "_valid"}, vld, 0);
    endtask

    // scoreboard: every DUT result pulse must match the oldest expected window
    always @(negedge clk) begin
        if (rst_n && vld) begin
            n_vec++;
            if (q_sum.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_valid: got sum %0d active %0d expected no pulse", sum, act);
            end else begin
                int es, ea;
                es = q_sum.pop_front();
                ea = q_act.pop_front();
                if (int'(sum) != es || int'(act) != ea) begin
                    n_err++;
                    $display("FAIL window: got sum %0d active %0d expected sum %0d active %0d",
                             sum, act, es, ea);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int h[N], ph[N];
        int gh, gph;
        logic [N-1:0] r;
        logic g;

        m_reset();
        cap_clear();
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        ena   = 1'b1;
        idle(4);

        // 1: ref leads gen by 5 on ch0
        chen = 4'b0001;
        idle(2);
        pair(4'b0001, 0, 5);
        idle(6);
        chk("t1_pd_err0", err_of(0), 5);
        cap_clear();
        cyc_drive('0, 1'b1);
        idle(6);
        chk("t1_pulses", cap_cnt, 1);
        chk("t1_sum", cap_sum, 5);
        chk("t1_active", cap_act, 1);
        idle(TO + 8);
        check_state("t1");

        // 2: gen leads ref by 7 on ch1, inverted then plain
        chen = 4'b0010;
        inv  = 4'b0010;
        idle(2);
        pair(4'b0010, 7, 0);
        idle(6);
        chk("t2_inv_pd_err1", err_of(1), 7);
        inv = 4'b0000;
        idle(2);
        pair(4'b0010, 7, 0);
        idle(6);
        chk("t2_pd_err1", err_of(1), -7);

        // 3: coincident edges on every channel
        chen = 4'b1111;
        idle(2);
        pair(4'b1111, 0, 0);
        idle(4);
        cap_clear();
        pair(4'b1111, 0, 0);
        idle(6);
        chk("t3_sum", cap_sum, 0);
        chk("t3_active", cap_act, 4);
        check_state("t3");

        // 4: gen missing on ch2 -> timeout, then cleared by a real measurement
        chen = 4'b0100;
        idle(2);
        cyc_drive(4'b0100, 1'b0);
        idle(TO + 8);
        chk("t4_to_pd_err2", err_of(2), MAXV);
        chk("t4_to_flag2", tmo[2], 1);
        pair(4'b0100, 0, 3);
        idle(6);
        chk("t4_pd_err2", err_of(2), 3);
        chk("t4_flag2_clear", tmo[2], 0);

        // 5: saturated errors on all channels, both signs
        chen = 4'b1111;
        idle(2);
        pair(4'b1111, 0, 150);
        idle(4);
        cap_clear();
        pair(4'b1111, 0, 0);
        idle(6);
        chk("t5_sum_pos", cap_sum, 508);
        chk("t5_active_pos", cap_act, 4);
        idle(2);
        pair(4'b1111, 150, 0);
        idle(4);
        cap_clear();
        pair(4'b1111, 0, 0);
        idle(6);
        chk("t5_sum_neg", cap_sum, -508);
        chk("t5_active_neg", cap_act, 4);

        // 6: reset in the middle of a REF_LEAD measurement
        chen = 4'b0001;
        idle(2);
        cyc_drive(4'b0001, 1'b0);
        idle(20);
        chk("t6_queue_drained", q_sum.size(), 0);
        @(negedge clk);
        rst_n = 1'b0;
        m_reset();
        #1;
        check_zero("t6_reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);
        cyc_drive('0, 1'b1);
        idle(3);
        chk("t6_lone_gen", err_of(0), 0);
        cyc_drive(4'b0001, 1'b0);
        idle(6);
        chk("t6_pd_err0", err_of(0), -4);

        // 6b: channel toggled off mid-window drops its contribution
        chen = 4'b0011;
        idle(2);
        pair(4'b0011, 0, 6);
        idle(4);
        chen = 4'b0001;
        idle(3);
        chen = 4'b0011;
        idle(3);
        cap_clear();
        pair(4'b0011, 0, 0);
        idle(6);
        chk("t6_toggle_sum", cap_sum, 6);
        chk("t6_toggle_active", cap_act, 1);
        idle(8);
        check_state("t6");

        // random bursts of free-running clocks, reconfigured while quiet
        for (int b = 0; b < 10; b++) begin
            chen = N'($urandom);
            inv  = N'($urandom);
            ena  = (b != 3);
            for (int k = 0; k < N; k++) begin
                h[k]  = $urandom_range(2, 30);
                ph[k] = $urandom_range(0, 59);
            end
            gh  = (b % 4 == 2) ? $urandom_range(100, 130) : $urandom_range(2, 30);
            gph = $urandom_range(0, 59);
            idle(2);
            for (int t = 0; t < 300; t++) begin
                for (int k = 0; k < N; k++) r[k] = (((t + ph[k]) / h[k]) % 2) == 1;
                g = (((t + gph) / gh) % 2) == 1;
                cyc_drive(r, g);
            end
            idle(TO + 8);
            check_state($sformatf("rnd%0d", b));
        end

        ena = 1'b1;
        idle(10);
        chk("end_queue_empty", q_sum.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
